// File: rtl/i2c_tmp_pkg.sv
// -----------------------------------------------------------------------------
// i2c_tmp_pkg
// Shared definitions for the I2C temperature request scheduler:
//   - UART command constants and response headers
//   - scheduler FSM state encoding
//   - request-class encoding (also the pending-flag index)
// -----------------------------------------------------------------------------
package i2c_tmp_pkg;

   // UART command words
   localparam logic [63:0] CMD_INIT   = 64'h1e00_0000_0000_0002;
   localparam logic [31:0] CMD_WR_HDR = 32'h1d00_0001;
   localparam logic [31:0] CMD_RD_HDR = 32'h1d01_0001;

   // UART response headers
   localparam logic [31:0] RSP_WR_OK  = 32'h1d00_aaaa;
   localparam logic [31:0] RSP_RD_OK  = 32'h1d01_aaaa;
   localparam logic [31:0] RSP_RD_ERR = 32'h1d01_eeee;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE,
      ST_FAIL
   } state_t;

   // Encoding order is also the arbitration order (lowest value wins).
   typedef enum logic [1:0] {
      REQ_INIT,
      REQ_WR,
      REQ_RD,
      REQ_POLL
   } req_t;

   function automatic logic req_is_read(input req_t r);
      return (r == REQ_RD) || (r == REQ_POLL);
   endfunction

endpackage

// File: rtl/i2c_tmp_sched_edge_sync.sv
// -----------------------------------------------------------------------------
// i2c_edge_sync
// Brings a level from the slow SCL domain into sys_clk through two flops and
// produces a one-cycle pulse on its rising edge. The pulse is valid three
// sys_clk edges after the source level rises.
// Ports:
//   sys_clk  in  : system clock
//   rst      in  : synchronous active-high reset
//   async_in in  : level from the engine (SCL domain)
//   rise     out : one-cycle pulse on a synchronized rising edge
// -----------------------------------------------------------------------------
module i2c_edge_sync (
   input  logic sys_clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= async_in;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rise = sync & ~sync_d;

endmodule

// File: rtl/i2c_tmp_sched.sv
// -----------------------------------------------------------------------------
// i2c_tmp_sched
// Shares one I2C read/write engine between four requesters (power-up config
// write, UART config write, UART register read, 1 s temperature poll).
// Requests are latched into single-slot pending flags, granted one at a time
// by fixed priority INIT > WR > RD > POLL, and each grant runs
// ISSUE (start strobe held) -> WAIT (completion or timeout) -> DONE/FAIL.
// Ports:
//   sys_clk, rst                 : 20 MHz clock, synchronous active-high reset
//   time_1s_en                   : 1 Hz tick (poll request, init delay)
//   rv_uart_vld, rv_uart_data    : UART command strobe and word
//   uart_send_en, uart_data      : UART response pulse and held word
//   eng_wr_rd, eng_wp_enable,
//   eng_reg_in                   : engine direction, start strobe, word
//   eng_ready, eng_rd_valid      : engine completion levels (SCL domain)
//   eng_rd_one, eng_rd_two       : engine read data for both sensors
//   tmp_one, tmp_two, tmp_valid  : last good temperatures
//   busy, timeout_cnt            : FSM not idle, saturating timeout count
// -----------------------------------------------------------------------------
module i2c_tmp_sched
   import i2c_tmp_pkg::*;
#(
   parameter int unsigned HOLD_CYC         = 1010,
   parameter int unsigned TIMEOUT_CYC      = 200000,
   parameter int unsigned INIT_DELAY_TICKS = 3,
   parameter logic [31:0] CFG_WORD         = 32'h0101_0160
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        time_1s_en,
   input  logic        rv_uart_vld,
   input  logic [63:0] rv_uart_data,
   output logic        uart_send_en,
   output logic [63:0] uart_data,
   output logic        eng_wr_rd,
   output logic        eng_wp_enable,
   output logic [31:0] eng_reg_in,
   input  logic        eng_ready,
   input  logic        eng_rd_valid,
   input  logic [15:0] eng_rd_one,
   input  logic [15:0] eng_rd_two,
   output logic [15:0] tmp_one,
   output logic [15:0] tmp_two,
   output logic        tmp_valid,
   output logic        busy,
   output logic [7:0]  timeout_cnt
);

   state_t      state, next_state;
   req_t        cur_req, grant;
   logic [3:0]  pend;
   logic [31:0] wr_data, rd_data, grant_word;
   logic [31:0] hold_cnt, wait_cnt;
   logic [7:0]  tick_cnt;
   logic        init_fired, init_hit;
   logic        uart_init, uart_wr, uart_rd;
   logic        launch, complete, to_done, to_fail;
   logic        rdy_rise, rdv_rise;

   i2c_edge_sync u_sync_ready (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .async_in (eng_ready),
      .rise     (rdy_rise)
   );

   i2c_edge_sync u_sync_rd_valid (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .async_in (eng_rd_valid),
      .rise     (rdv_rise)
   );

   // ---------------- request decode ----------------
   assign uart_init = rv_uart_vld && (rv_uart_data == CMD_INIT);
   assign uart_wr   = rv_uart_vld && (rv_uart_data[63:32] == CMD_WR_HDR);
   assign uart_rd   = rv_uart_vld && (rv_uart_data[63:32] == CMD_RD_HDR);
   assign init_hit  = time_1s_en && !init_fired &&
                      (tick_cnt == 8'(INIT_DELAY_TICKS - 1));

   assign launch    = (state == ST_IDLE) && (pend != 4'b0000);
   assign complete  = req_is_read(cur_req) ? rdv_rise : rdy_rise;
   assign to_done   = (state == ST_WAIT) && (next_state == ST_DONE);
   assign to_fail   = (state == ST_WAIT) && (next_state == ST_FAIL);

   always_comb begin
      grant = REQ_POLL;
      if (pend[REQ_INIT])    grant = REQ_INIT;
      else if (pend[REQ_WR]) grant = REQ_WR;
      else if (pend[REQ_RD]) grant = REQ_RD;
   end

   always_comb begin
      unique case (grant)
         REQ_INIT: grant_word = CFG_WORD;
         REQ_WR:   grant_word = wr_data;
         REQ_RD:   grant_word = rd_data;
         default:  grant_word = 32'h0;
      endcase
   end

   // Pending flags: the grant clears first so a same-cycle re-request of the
   // granted class is kept for the next round.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         pend       <= 4'b0000;
         wr_data    <= 32'h0;
         rd_data    <= 32'h0;
         tick_cnt   <= 8'd0;
         init_fired <= 1'b0;
      end else begin
         if (launch) pend[grant] <= 1'b0;
         if (uart_init || init_hit) pend[REQ_INIT] <= 1'b1;
         if (uart_wr) begin
            pend[REQ_WR] <= 1'b1;
            wr_data      <= rv_uart_data[31:0];
         end
         if (uart_rd) begin
            pend[REQ_RD] <= 1'b1;
            rd_data      <= rv_uart_data[31:0];
         end
         if (time_1s_en) pend[REQ_POLL] <= 1'b1;
         // The init delay counter freezes once the config write has fired.
         if (time_1s_en && !init_fired) begin
            tick_cnt <= tick_cnt + 8'd1;
            if (init_hit) init_fired <= 1'b1;
         end
      end
   end

   // ---------------- FSM ----------------
   // NOTE: clocked state uses <= so every flop samples pre-edge values;
   // blocking assignments here would make results depend on block order.
   always_ff @(posedge sys_clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:  if (launch) next_state = ST_ISSUE;
         ST_ISSUE: if (hold_cnt == HOLD_CYC - 1) next_state = ST_WAIT;
         ST_WAIT: begin
            if (complete)                         next_state = ST_DONE;
            else if (wait_cnt == TIMEOUT_CYC - 1) next_state = ST_FAIL;
         end
         ST_DONE:  next_state = ST_IDLE;
         ST_FAIL:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      eng_wp_enable = (state == ST_ISSUE);
      busy          = (state != ST_IDLE);
   end

   // Phase counters restart whenever their state is left, so each ISSUE and
   // WAIT visit gets a fresh budget.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         hold_cnt <= 32'h0;
         wait_cnt <= 32'h0;
      end else begin
         hold_cnt <= (state == ST_ISSUE) ? hold_cnt + 32'd1 : 32'h0;
         wait_cnt <= (state == ST_WAIT)  ? wait_cnt + 32'd1 : 32'h0;
      end
   end

   // ---------------- datapath / responses ----------------
   // Results are registered on the WAIT->DONE/FAIL edge so they are visible
   // during the DONE/FAIL cycle itself.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         cur_req      <= REQ_INIT;
         eng_wr_rd    <= 1'b0;
         eng_reg_in   <= 32'h0;
         uart_send_en <= 1'b0;
         uart_data    <= 64'h0;
         tmp_one      <= 16'h0;
         tmp_two      <= 16'h0;
         tmp_valid    <= 1'b0;
         timeout_cnt  <= 8'h0;
      end else begin
         uart_send_en <= 1'b0;
         if (launch) begin
            cur_req    <= grant;
            eng_wr_rd  <= req_is_read(grant);
            eng_reg_in <= grant_word;
         end
         if (to_done) begin
            if (req_is_read(cur_req)) begin
               tmp_one   <= eng_rd_one;
               tmp_two   <= eng_rd_two;
               tmp_valid <= 1'b1;
            end
            if (cur_req == REQ_RD) begin
               uart_send_en <= 1'b1;
               uart_data    <= {RSP_RD_OK, eng_rd_two, eng_rd_one};
            end else if (cur_req == REQ_WR) begin
               uart_send_en <= 1'b1;
               uart_data    <= {RSP_WR_OK, 32'h0};
            end
         end
         if (to_fail) begin
            if (timeout_cnt != 8'hff) timeout_cnt <= timeout_cnt + 8'd1;
            if (cur_req == REQ_RD) begin
               uart_send_en <= 1'b1;
               uart_data    <= {RSP_RD_ERR, 32'h0};
            end
         end
      end
   end

endmodule

// File: doc/i2c_tmp_sched.md
# i2c_tmp_sched

Request scheduler for the digital-board I2C temperature engine. It shares one I2C read/write engine between four requesters: the power-up config write, UART config write, UART register read and 1 s temperature poll. It latches requests, grants one at a time by fixed priority, holds the engine start strobe long enough for the slow SCL domain, and waits for completion or timeout. It then publishes temperatures and UART responses. It sits between the UART command decoder and the I2C engine on the 20 MHz `sys_clk`.

## Interface
Parameters:
- `HOLD_CYC`, 1010: `sys_clk` cycles that `eng_wp_enable` is held high (5 SCL periods at 202 cycles each).
- `TIMEOUT_CYC`, 200000: maximum cycles in WAIT (10 ms).
- `INIT_DELAY_TICKS`, 3: `time_1s_en` ticks after reset before the automatic config write.
- `CFG_WORD`, 32'h0101_0160: register word used for every init write.

Ports:
- `sys_clk` in 1: sole clock, 20 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `time_1s_en` in 1: one-cycle tick, 1 Hz.
- `rv_uart_vld` in 1: UART command strobe.
- `rv_uart_data` in 64: UART command word.
- `uart_send_en` out 1: one-cycle response strobe.
- `uart_data` out 64: response word.
- `eng_wr_rd` out 1: 0 = write, 1 = read.
- `eng_wp_enable` out 1: engine start strobe.
- `eng_reg_in` out 32: engine address/data word.
- `eng_ready` in 1: engine write-done level, SCL domain.
- `eng_rd_valid` in 1: engine read-valid level, SCL domain.
- `eng_rd_one` in 16: sensor 1 read data.
- `eng_rd_two` in 16: sensor 2 read data.
- `tmp_one` out 16: last good sensor 1 temperature.
- `tmp_two` out 16: last good sensor 2 temperature.
- `tmp_valid` out 1: set after the first successful read.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `timeout_cnt` out 8: saturating count of timeouts.

## Operation
Request decode. Each decode sets one pending flag:
- `rv_uart_vld` with data == 64'h1e00_0000_0000_0002 sets INIT.
- `rv_uart_vld` with [63:32] == 32'h1d00_0001 sets WR and stores [31:0].
- `rv_uart_vld` with [63:32] == 32'h1d01_0001 sets RD and stores [31:0].
- `time_1s_en` sets POLL.
- The tick counter reaches `INIT_DELAY_TICKS`: sets INIT exactly once per reset, and the counter then stops.

Pending-flag rules:
- Each class holds a single pending slot. A repeated request while pending overwrites the stored data (last wins) and is not queued twice.
- A flag clears when its request is granted.
- A UART command and a tick arriving in the same cycle are both latched.

Arbitration happens in IDLE only, with fixed priority INIT > WR > RD > POLL. Granted operations drive:
- INIT: `eng_wr_rd`=0, `eng_reg_in`=`CFG_WORD`.
- WR: `eng_wr_rd`=0, `eng_reg_in`=stored data.
- RD: `eng_wr_rd`=1, `eng_reg_in`=stored data.
- POLL: `eng_wr_rd`=1, `eng_reg_in`=0.

FSM:
- IDLE: moves to ISSUE when any flag is pending. `eng_wr_rd` and `eng_reg_in` are loaded on this transition.
- ISSUE: `eng_wp_enable`=1 for `HOLD_CYC` cycles, then WAIT.
- WAIT: waits for the completion edge. A write completes on the rising edge of `eng_ready`; a read completes on the rising edge of `eng_rd_valid`. On the edge, go to DONE. If `TIMEOUT_CYC` expires first, go to FAIL.
- DONE (1 cycle):
  - Any read: captures `tmp_one`/`tmp_two` and sets `tmp_valid`.
  - RD: sends {32'h1d01_aaaa, two, one}.
  - WR: sends {32'h1d00_aaaa, 32'h0}.
  - INIT and POLL send nothing.
  - Then IDLE.
- FAIL (1 cycle): increments `timeout_cnt` (saturates at 255). RD sends {32'h1d01_eeee, 32'h0}. Temperatures are unchanged. Then IDLE.

## Timing
- Reset values: all outputs 0; FSM in IDLE; all flags, counters and stored data 0.
- `eng_ready` and `eng_rd_valid` pass through a 2-flop synchronizer plus an edge register. An engine edge is seen 3 `sys_clk` cycles later.
- Request strobe to pending flag: 1 cycle. Pending to IDLE→ISSUE: 1 cycle. `eng_wp_enable` high from the first ISSUE cycle for exactly `HOLD_CYC` cycles.
- `eng_wr_rd` and `eng_reg_in` stay stable from ISSUE entry through the DONE/FAIL exit.
- `uart_send_en` is a single-cycle pulse registered in DONE/FAIL, with `uart_data` valid in the same cycle and held until the next response.
- `tmp_*` update in the same cycle as DONE.
- Completion edges seen outside WAIT are ignored. The timeout counter restarts on each WAIT entry.
- Synchronous `rst` mid-operation: `eng_wp_enable` drops on the next edge, FSM goes to IDLE, and pending requests are discarded.

## Structure
- Shared package `i2c_tmp_pkg`, holding:
  - the command constants (64'h1e00_0000_0000_0002, 32'h1d00_0001, 32'h1d01_0001);
  - the response headers (aaaa, eeee forms);
  - the FSM state enum;
  - the request-class enum.
- One sub-module, `i2c_edge_sync`: 2-flop synchronizer plus rising-edge pulse, instantiated for `eng_ready` and `eng_rd_valid`.

## Test plan
- Reset, then 3 `time_1s_en` ticks → INIT write with `eng_reg_in`=32'h0101_0160 and `eng_wr_rd`=0. `eng_wp_enable` held 1010 cycles; no UART response.
- UART 64'h1d01_0001_0000_0000; engine returns `rd_valid` with one=16'h02f6, two=16'h0301 → `uart_data`=64'h1d01_aaaa_0301_02f6 with a 1-cycle `uart_send_en`, and `tmp_one`=16'h02f6.
- `time_1s_en` and UART 32'h1d00_0001 write in the same cycle → WR granted first with ack 64'h1d00_aaaa_0000_0000, then POLL, which updates `tmp_*` only.
- RD with no `rd_valid` for 200000 cycles → response 64'h1d01_eeee_0000_0000, `timeout_cnt`=1, `tmp_*` unchanged.
- Two RD commands (addresses 0x00 then 0x01) while busy with POLL → a single RD issued with `eng_reg_in`=0x00000001.
- `rst` asserted during ISSUE → `eng_wp_enable`=0 next cycle, and outputs, flags and counters (including the INIT tick counter) return to 0.
